// File: rtl/frog_pkg.sv
// Shared definitions for the Frog program loader and CPU.
// Contents:
//   frog_state_e    loader FSM states
//   FROG_ADDR_W     program RAM address width (256 words)
//   FROG_DATA_W     program RAM word width (two bytes per word)
//   FROG_SYNC_BYTE  frame header byte
//   FROG_TIMEOUT    default idle-cycle limit inside a frame
//   frog_is_busy()  true for states that belong to an open frame
package frog_pkg;

  localparam int         FROG_ADDR_W    = 8;
  localparam int         FROG_DATA_W    = 16;
  localparam logic [7:0] FROG_SYNC_BYTE = 8'hA5;
  localparam int         FROG_TIMEOUT   = 50000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_COUNT = 3'd1,
    S_HI    = 3'd2,
    S_LO    = 3'd3,
    S_WRITE = 3'd4,
    S_CSUM  = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } frog_state_e;

  function automatic logic frog_is_busy(input frog_state_e s);
    logic r;
    case (s)
      S_COUNT, S_HI, S_LO, S_WRITE, S_CSUM: r = 1'b1;
      default:                              r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/frog_idle_timer.sv
// Loadable idle down-counter used to detect a stalled byte stream.
// Ports:
//   clk         clock, posedge
//   rst_n       synchronous active-low reset
//   i_load      reload the counter with i_load_val (restarts the idle window)
//   i_load_val  reload value (idle cycles allowed minus one)
//   i_en        counting enabled; counter decrements and saturates at zero
//   o_expired   counting enabled and the window is used up
module frog_idle_timer #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_en,
  output logic             o_expired
);

  logic [WIDTH-1:0] r_cnt;

  // Idle counter: reload has priority over counting down.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_load_val;
    end else if (i_en && (r_cnt != '0)) begin
      r_cnt <= r_cnt - WIDTH'(1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_expired = i_en && (r_cnt == '0);

endmodule

// File: rtl/frog_prog_loader.sv
// Frog instruction-memory loader: parses SYNC, N, N x {hi, lo}, CHK frames
// from a byte stream and writes the words to program RAM from address 0.
// The CPU is held (cpu_run=0) until a frame passes its XOR checksum.
// Ports:
//   clk, rst_n            clock and synchronous active-low reset
//   in_data/in_valid      byte source; a byte is taken when in_valid & in_ready
//   in_ready              loader accepts a byte this cycle (low in WRITE)
//   mem_we/addr/wdata     one-cycle RAM write strobe with address and word
//   cpu_run               program valid, CPU may fetch
//   load_err              sticky checksum/timeout flag, cleared by next SYNC
//   busy                  a frame is in progress
module frog_prog_loader
  import frog_pkg::*;
#(
  parameter int         ADDR_W    = FROG_ADDR_W,
  parameter int         DATA_W    = FROG_DATA_W,
  parameter logic [7:0] SYNC_BYTE = FROG_SYNC_BYTE,
  parameter int         TIMEOUT   = FROG_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_run,
  output logic              load_err,
  output logic              busy
);

  // Timer holds TIMEOUT-1 so it reads zero during the TIMEOUT-th idle cycle.
  localparam int            TW    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLOAD = (TIMEOUT == 0) ? '0 : TW'(TIMEOUT - 1);
  localparam logic          TO_EN = (TIMEOUT != 0);

  frog_state_e       r_state;
  frog_state_e       w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [8:0]        r_remain;      // words still to write, 1..256
  logic [7:0]        r_chk;
  logic [7:0]        r_hi;
  logic [DATA_W-1:0] r_wdata;
  logic              r_in_ready;
  logic              r_mem_we;
  logic              r_cpu_run;
  logic              r_load_err;
  logic              r_busy;

  logic w_accept;
  logic w_sync;
  logic w_timed;
  logic w_expired;
  logic w_timeout;

  assign w_accept = in_valid & r_in_ready;
  assign w_sync   = w_accept && (in_data == SYNC_BYTE);
  assign w_timed  = (r_state == S_COUNT) || (r_state == S_HI) ||
                    (r_state == S_LO)    || (r_state == S_CSUM);
  // An accepted byte in the last idle cycle still counts as on time.
  assign w_timeout = TO_EN & w_timed & w_expired & ~w_accept;

  frog_idle_timer #(.WIDTH(TW)) u_idle_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_load     (~w_timed | w_accept),
    .i_load_val (TLOAD),
    .i_en       (w_timed),
    .o_expired  (w_expired)
  );

  // Next-state decode for the frame parser.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_sync) w_state_nxt = S_COUNT;
        else        w_state_nxt = r_state;
      end
      S_COUNT: begin
        if (w_accept)       w_state_nxt = S_HI;
        else if (w_timeout) w_state_nxt = S_ERROR;
        else                w_state_nxt = r_state;
      end
      S_HI: begin
        if (w_accept)       w_state_nxt = S_LO;
        else if (w_timeout) w_state_nxt = S_ERROR;
        else                w_state_nxt = r_state;
      end
      S_LO: begin
        if (w_accept)       w_state_nxt = S_WRITE;
        else if (w_timeout) w_state_nxt = S_ERROR;
        else                w_state_nxt = r_state;
      end
      S_WRITE: begin
        if (r_remain == 9'd1) w_state_nxt = S_CSUM;
        else                  w_state_nxt = S_HI;
      end
      S_CSUM: begin
        if (w_accept) begin
          if (in_data == r_chk) w_state_nxt = S_DONE;
          else                  w_state_nxt = S_ERROR;
        end else if (w_timeout) begin
          w_state_nxt = S_ERROR;
        end else begin
          w_state_nxt = r_state;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register, datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_remain   <= 9'd0;
      r_chk      <= 8'd0;
      r_hi       <= 8'd0;
      r_wdata    <= '0;
      r_in_ready <= 1'b0;
      r_mem_we   <= 1'b0;
      r_cpu_run  <= 1'b0;
      r_load_err <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      // Outputs follow the state being entered so they line up with it.
      r_in_ready <= (w_state_nxt != S_WRITE);
      r_mem_we   <= (w_state_nxt == S_WRITE);
      r_busy     <= frog_is_busy(w_state_nxt);
      case (r_state)
        S_IDLE, S_DONE, S_ERROR: begin
          if (w_sync) begin
            r_chk      <= 8'd0;
            r_addr     <= '0;
            r_cpu_run  <= 1'b0;
            r_load_err <= 1'b0;
          end
        end
        S_COUNT: begin
          if (w_accept) begin
            r_remain <= (in_data == 8'd0) ? 9'd256 : {1'b0, in_data};
            r_chk    <= r_chk ^ in_data;
          end else if (w_timeout) begin
            r_load_err <= 1'b1;
          end
        end
        S_HI: begin
          if (w_accept) begin
            r_hi  <= in_data;
            r_chk <= r_chk ^ in_data;
          end else if (w_timeout) begin
            r_load_err <= 1'b1;
          end
        end
        S_LO: begin
          if (w_accept) begin
            r_wdata <= {r_hi, in_data};
            r_chk   <= r_chk ^ in_data;
          end else if (w_timeout) begin
            r_load_err <= 1'b1;
          end
        end
        S_WRITE: begin
          r_addr   <= r_addr + ADDR_W'(1);
          r_remain <= r_remain - 9'd1;
        end
        S_CSUM: begin
          if (w_accept) begin
            if (in_data == r_chk) r_cpu_run  <= 1'b1;
            else                  r_load_err <= 1'b1;
          end else if (w_timeout) begin
            r_load_err <= 1'b1;
          end
        end
        default: begin
          r_addr <= r_addr;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign cpu_run   = r_cpu_run;
  assign load_err  = r_load_err;
  assign busy      = r_busy;

endmodule

// File: tb/tb_frog_prog_loader.sv
// Self-checking bench for frog_prog_loader: table of short frames, hand
// sequences for reset/timeout/restart corners, and random frames checked
// against a frame-level model (expected write list and checksum verdict).
module tb_frog_prog_loader;
  import frog_pkg::*;

  localparam int TO = 20;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic        cpu_run;
  logic        load_err;
  logic        busy;

  always #5 clk = ~clk;

  frog_prog_loader #(
    .ADDR_W(8), .DATA_W(16), .SYNC_BYTE(8'hA5), .TIMEOUT(TO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .cpu_run(cpu_run), .load_err(load_err), .busy(busy)
  );

  int checks = 0;
  int errors = 0;

  // Write monitor: captures every strobe; flags strobes with in_ready high
  // or strobes longer than one cycle.
  logic [23:0] cap_q[$];
  int          mon_bad = 0;
  logic        prev_we = 1'b0;
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      cap_q.push_back({mem_addr, mem_wdata});
      if (in_ready !== 1'b0) mon_bad++;
      if (prev_we === 1'b1) mon_bad++;
    end
    prev_we = mem_we;
  end

  // Global run bound.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Present one byte after 'gap' idle cycles and hold it until accepted.
  task automatic send_byte(input logic [7:0] b, input int gap);
    int n;
    repeat (gap) @(negedge clk);
    in_data  = b;
    in_valid = 1'b1;
    n = 0;
    while (in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (n >= 50) begin
      checks++;
      errors++;
      $display("FAIL handshake_bound actual=%0d required=<50", n);
    end
  endtask

  // Frame model input: words to load.
  logic [15:0] fw[$];

  task automatic send_frame(input logic [7:0] nb, input bit bad, input int maxgap, input bit fixed);
    logic [7:0] c;
    int g;
    c = nb;
    g = fixed ? maxgap : int'($urandom_range(0, maxgap));
    send_byte(8'hA5, g);
    g = fixed ? maxgap : int'($urandom_range(0, maxgap));
    send_byte(nb, g);
    foreach (fw[i]) begin
      g = fixed ? maxgap : int'($urandom_range(0, maxgap));
      send_byte(fw[i][15:8], g);
      g = fixed ? maxgap : int'($urandom_range(0, maxgap));
      send_byte(fw[i][7:0], g);
      c = c ^ fw[i][15:8] ^ fw[i][7:0];
    end
    g = fixed ? maxgap : int'($urandom_range(0, maxgap));
    send_byte(bad ? ~c : c, g);
  endtask

  // Compare captured writes and status against the frame model.
  task automatic check_frame(input string tag, input int base, input bit bad);
    repeat (2) @(negedge clk);
    check({tag, "_nwrites"}, cap_q.size() - base, fw.size());
    for (int i = 0; i < fw.size(); i++) begin
      if (base + i < cap_q.size())
        check({tag, "_write"}, cap_q[base + i], {8'(i), fw[i]});
    end
    check({tag, "_cpu_run"}, cpu_run, !bad);
    check({tag, "_load_err"}, load_err, bad);
    check({tag, "_busy"}, busy, 1'b0);
    check({tag, "_in_ready"}, in_ready, 1'b1);
  endtask

  typedef struct {
    logic [63:0] b;     // bytes, first byte in the top 8 bits
    int          len;
    int          nwr;
    logic [15:0] w0;
    logic        run;
    logic        err;
  } vec_t;

  vec_t tbl[7];

  initial begin
    int base;
    bit bad;
    int n;

    tbl[0] = '{64'hA5_02_12_34_AB_CD_42_00, 7, 2, 16'h1234, 1'b1, 1'b0};
    tbl[1] = '{64'hA5_02_12_34_AB_CD_00_00, 7, 2, 16'h1234, 1'b0, 1'b1};
    tbl[2] = '{64'hA5_02_12_34_AB_CD_42_00, 7, 2, 16'h1234, 1'b1, 1'b0};
    tbl[3] = '{64'h33_44_00_00_00_00_00_00, 2, 0, 16'h0000, 1'b1, 1'b0};
    tbl[4] = '{64'h00_FF_5A_A5_01_A5_5A_FE, 8, 1, 16'hA55A, 1'b1, 1'b0};
    tbl[5] = '{64'hA5_01_FF_FF_00_00_00_00, 5, 1, 16'hFFFF, 1'b0, 1'b1};
    tbl[6] = '{64'hA5_01_00_00_01_00_00_00, 5, 1, 16'h0000, 1'b1, 1'b0};

    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_in_ready", in_ready, 1'b0);
    check("rst_mem_we", mem_we, 1'b0);
    check("rst_mem_addr", mem_addr, 8'h00);
    check("rst_mem_wdata", mem_wdata, 16'h0000);
    check("rst_cpu_run", cpu_run, 1'b0);
    check("rst_load_err", load_err, 1'b0);
    check("rst_busy", busy, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1'b1);

    // Table of short frames, bytes sent back to back.
    for (int v = 0; v < 7; v++) begin
      base = cap_q.size();
      for (int k = 0; k < tbl[v].len; k++) send_byte(tbl[v].b[63 - 8*k -: 8], 0);
      repeat (2) @(negedge clk);
      check("tbl_nwrites", cap_q.size() - base, tbl[v].nwr);
      if (tbl[v].nwr > 0 && cap_q.size() > base)
        check("tbl_first_write", cap_q[base], {8'h00, tbl[v].w0});
      if (tbl[v].nwr > 1 && cap_q.size() > base + 1)
        check("tbl_second_write", cap_q[base + 1], 24'h01ABCD);
      check("tbl_cpu_run", cpu_run, tbl[v].run);
      check("tbl_load_err", load_err, tbl[v].err);
      check("tbl_busy", busy, 1'b0);
    end

    // Restart from DONE: cpu_run drops right after the SYNC byte.
    check("done_cpu_run", cpu_run, 1'b1);
    base = cap_q.size();
    send_byte(8'hA5, 0);
    check("restart_cpu_run_drop", cpu_run, 1'b0);
    check("restart_busy", busy, 1'b1);
    send_byte(8'h01, 0);
    send_byte(8'h12, 0);
    // Idle timeout: 19 idle cycles still busy, the 20th ends the frame.
    repeat (TO - 1) @(negedge clk);
    check("timeout_edge_busy", busy, 1'b1);
    check("timeout_edge_err", load_err, 1'b0);
    @(negedge clk);
    check("timeout_busy", busy, 1'b0);
    check("timeout_load_err", load_err, 1'b1);
    check("timeout_cpu_run", cpu_run, 1'b0);
    check("timeout_no_write", cap_q.size() - base, 0);

    // 256-word frame (N=0), word value = index; address wraps to 0.
    fw.delete();
    for (int i = 0; i < 256; i++) fw.push_back(16'(i));
    base = cap_q.size();
    send_frame(8'h00, 1'b0, 0, 1'b1);
    check_frame("n256", base, 1'b0);
    check("n256_addr_wrap", mem_addr, 8'h00);

    // Gaps just inside the idle limit are not a timeout.
    fw.delete();
    fw.push_back(16'h5A3C);
    base = cap_q.size();
    send_frame(8'h01, 1'b0, TO - 1, 1'b1);
    check_frame("slow", base, 1'b0);

    // Reset one cycle after the hi byte aborts the frame.
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h11, 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_in_ready", in_ready, 1'b0);
    check("midrst_busy", busy, 1'b0);
    check("midrst_cpu_run", cpu_run, 1'b0);
    check("midrst_load_err", load_err, 1'b0);
    check("midrst_mem_addr", mem_addr, 8'h00);
    check("midrst_mem_wdata", mem_wdata, 16'h0000);
    check("midrst_mem_we", mem_we, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_ready_back", in_ready, 1'b1);

    // Random frames with random gaps and occasional bad checksum.
    for (int f = 0; f < 10; f++) begin
      fw.delete();
      n = $urandom_range(1, 10);
      for (int i = 0; i < n; i++)
        fw.push_back(($urandom_range(0, 4) == 0) ? 16'hA5A5 : 16'($urandom));
      bad = ($urandom_range(0, 3) == 0);
      base = cap_q.size();
      send_frame(8'(n), bad, (f % 2 == 0) ? 0 : 12, 1'b0);
      check_frame("rand", base, bad);
    end

    check("write_strobe_rules", mon_bad, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
